// File: rtl/egd_mb_sequencer.sv
// Macroblock header sequencer: requests six exp-Golomb elements per macroblock from the
// upstream decoder, assembles the fields and maintains the running QP.
module egd_mb_sequencer #(
    parameter int unsigned QP_INIT = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] mb_count,
    input  logic [7:0] egd_value,
    output logic [1:0] exp_golomb_sel,
    output logic       busy,
    output logic       mb_valid,
    output logic [7:0] mb_type,
    output logic [7:0] ref_idx,
    output logic [7:0] mvd_x,
    output logic [7:0] mvd_y,
    output logic [7:0] cbp,
    output logic [5:0] qp,
    output logic [3:0] mb_index,
    output logic       done
);

    localparam logic [5:0] QP_RST = 6'(QP_INIT);

    typedef enum logic [1:0] {S_IDLE, S_PARSE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  mb_cnt_q, mb_cnt_d;
    logic [3:0]  mb_total_q, mb_total_d;
    logic        accept_start;
    logic        last_elem;

    logic [7:0]  sh_q [5];
    logic [7:0]  mb_type_q, ref_idx_q, mvd_x_q, mvd_y_q, cbp_q;
    logic [5:0]  qp_q;
    logic [3:0]  mb_index_q;
    logic        mb_valid_q;

    logic signed [6:0] delta_sat;
    logic signed [7:0] qp_sum;
    logic signed [7:0] qp_wrapped;

    assign last_elem = (state_q == S_PARSE) && (idx_q == 3'd5);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mb_cnt_d     = mb_cnt_q;
        mb_total_d   = mb_total_q;
        accept_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mb_count != 4'd0) begin
                        state_d      = S_PARSE;
                        idx_d        = 3'd0;
                        mb_cnt_d     = 4'd0;
                        mb_total_d   = mb_count;
                        accept_start = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PARSE: begin
                if (idx_q == 3'd5) begin
                    idx_d = 3'd0;
                    if (mb_cnt_q == mb_total_q - 4'd1) begin
                        state_d = S_DONE;
                    end else begin
                        mb_cnt_d = mb_cnt_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Element type must resolve in the same cycle so the decoder can produce egd_value.
    always_comb begin
        exp_golomb_sel = 2'b00;
        if (state_q == S_PARSE) begin
            case (idx_q)
                3'd1:                exp_golomb_sel = 2'b11;
                3'd2, 3'd3, 3'd5:    exp_golomb_sel = 2'b01;
                default:             exp_golomb_sel = 2'b00;
            endcase
        end
    end

    // Saturate the delta first, then a single +/-52 correction keeps QP in 0..51.
    always_comb begin
        if ($signed(egd_value) > 8'sd25) begin
            delta_sat = 7'sd25;
        end else if ($signed(egd_value) < -8'sd26) begin
            delta_sat = -7'sd26;
        end else begin
            delta_sat = egd_value[6:0];
        end
        qp_sum = $signed({2'b00, qp_q}) + $signed({delta_sat[6], delta_sat});
        if (qp_sum < 8'sd0) begin
            qp_wrapped = qp_sum + 8'sd52;
        end else if (qp_sum > 8'sd51) begin
            qp_wrapped = qp_sum - 8'sd52;
        end else begin
            qp_wrapped = qp_sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            mb_cnt_q   <= 4'd0;
            mb_total_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mb_cnt_q   <= mb_cnt_d;
            mb_total_q <= mb_total_d;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_shadow
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sh_q[gi] <= 8'd0;
            end else if ((state_q == S_PARSE) && (idx_q == 3'(gi))) begin
                sh_q[gi] <= egd_value;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mb_type_q  <= 8'd0;
            ref_idx_q  <= 8'd0;
            mvd_x_q    <= 8'd0;
            mvd_y_q    <= 8'd0;
            cbp_q      <= 8'd0;
            qp_q       <= QP_RST;
            mb_index_q <= 4'd0;
            mb_valid_q <= 1'b0;
        end else begin
            mb_valid_q <= last_elem;
            if (accept_start) begin
                qp_q <= QP_RST;
            end else if (last_elem) begin
                mb_type_q  <= sh_q[0];
                ref_idx_q  <= sh_q[1];
                mvd_x_q    <= sh_q[2];
                mvd_y_q    <= sh_q[3];
                cbp_q      <= sh_q[4];
                qp_q       <= qp_wrapped[5:0];
                mb_index_q <= mb_cnt_q;
            end
        end
    end

    assign busy     = (state_q == S_PARSE);
    assign done     = (state_q == S_DONE);
    assign mb_valid = mb_valid_q;
    assign mb_type  = mb_type_q;
    assign ref_idx  = ref_idx_q;
    assign mvd_x    = mvd_x_q;
    assign mvd_y    = mvd_y_q;
    assign cbp      = cbp_q;
    assign qp       = qp_q;
    assign mb_index = mb_index_q;

endmodule

// File: tb/tb_egd_mb_sequencer.sv
// Directed bench for egd_mb_sequencer: default-QP instance plus a QP_INIT=50 instance
// sharing the same stimulus.
module tb_egd_mb_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] mb_count;
    logic [7:0] egd_value;

    logic [1:0] sel, sel50;
    logic       busy, busy50, mb_valid, mb_valid50, done, done50;
    logic [7:0] mb_type, ref_idx, mvd_x, mvd_y, cbp;
    logic [7:0] mb_type50, ref_idx50, mvd_x50, mvd_y50, cbp50;
    logic [5:0] qp, qp50;
    logic [3:0] mb_index, mb_index50;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    egd_mb_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mb_count(mb_count),
        .egd_value(egd_value), .exp_golomb_sel(sel), .busy(busy), .mb_valid(mb_valid),
        .mb_type(mb_type), .ref_idx(ref_idx), .mvd_x(mvd_x), .mvd_y(mvd_y), .cbp(cbp),
        .qp(qp), .mb_index(mb_index), .done(done)
    );

    egd_mb_sequencer #(.QP_INIT(50)) dut50 (
        .clk(clk), .reset_n(reset_n), .start(start), .mb_count(mb_count),
        .egd_value(egd_value), .exp_golomb_sel(sel50), .busy(busy50), .mb_valid(mb_valid50),
        .mb_type(mb_type50), .ref_idx(ref_idx50), .mvd_x(mvd_x50), .mvd_y(mvd_y50), .cbp(cbp50),
        .qp(qp50), .mb_index(mb_index50), .done(done50)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_sel(input int k);
        case (k)
            1:       return 2'b11;
            2, 3, 5: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Feeds one macroblock; entered with the DUT in PARSE at idx0, leaves one cycle
    // after the idx5 capture edge (where mb_valid should be up).
    task automatic do_mb(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5,
                         input bit pulse_start);
        logic [7:0] e [6];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e5;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sel_idx%0d", k), 32'(sel), 32'(exp_sel(k)));
            chk($sformatf("busy_idx%0d", k), 32'(busy), 32'd1);
            chk($sformatf("done_idx%0d", k), 32'(done), 32'd0);
            if (k > 0) chk($sformatf("mb_valid_idx%0d", k), 32'(mb_valid), 32'd0);
            egd_value = e[k];
            start     = (pulse_start && k == 2);
            if (start) mb_count = 4'd5;
            step();
        end
        start = 1'b0;
    endtask

    task automatic check_mb(input logic [7:0] t, input logic [7:0] r, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] c, input logic [5:0] q,
                            input logic [3:0] i, input logic d);
        chk("mb_valid", 32'(mb_valid), 32'd1);
        chk("mb_type", 32'(mb_type), 32'(t));
        chk("ref_idx", 32'(ref_idx), 32'(r));
        chk("mvd_x", 32'(mvd_x), 32'(x));
        chk("mvd_y", 32'(mvd_y), 32'(y));
        chk("cbp", 32'(cbp), 32'(c));
        chk("qp", 32'(qp), 32'(q));
        chk("mb_index", 32'(mb_index), 32'(i));
        chk("done", 32'(done), 32'(d));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mb_valid"}, 32'(mb_valid), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_fields"}, {mb_type, ref_idx, mvd_x, mvd_y}, 32'd0);
        chk({tag, "_cbp"}, 32'(cbp), 32'd0);
        chk({tag, "_qp"}, 32'(qp), 32'd26);
        chk({tag, "_qp50"}, 32'(qp50), 32'd50);
        chk({tag, "_mb_index"}, 32'(mb_index), 32'd0);
    endtask

    task automatic start_run(input logic [3:0] n);
        start    = 1'b1;
        mb_count = n;
        step();
        start    = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b1;
        start     = 1'b0;
        mb_count  = 4'd0;
        egd_value = 8'd0;
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Single macroblock, QP 26 + (-3) = 23
        start_run(4'd1);
        do_mb(8'd3, 8'd0, 8'hFE, 8'd5, 8'd15, 8'hFD, 1'b0);
        check_mb(8'd3, 8'd0, 8'hFE, 8'd5, 8'd15, 6'd23, 4'd0, 1'b1);
        chk("single_qp50", 32'(qp50), 32'd47);
        step();
        chk("single_after_valid", 32'(mb_valid), 32'd0);
        chk("single_after_done", 32'(done), 32'd0);
        chk("single_after_busy", 32'(busy), 32'd0);
        chk("single_hold_type", 32'(mb_type), 32'd3);
        chk("single_hold_qp", 32'(qp), 32'd23);

        // QP wrap on the QP_INIT=50 instance: 50+5 -> 3, 3-10 -> 45
        start_run(4'd2);
        do_mb(8'd7, 8'd1, 8'd2, 8'd3, 8'd4, 8'h05, 1'b0);
        check_mb(8'd7, 8'd1, 8'd2, 8'd3, 8'd4, 6'd31, 4'd0, 1'b0);
        chk("wrap_qp50_a", 32'(qp50), 32'd3);
        do_mb(8'd9, 8'd2, 8'd3, 8'd4, 8'd5, 8'hF6, 1'b0);
        check_mb(8'd9, 8'd2, 8'd3, 8'd4, 8'd5, 6'd21, 4'd1, 1'b1);
        chk("wrap_qp50_b", 32'(qp50), 32'd45);
        step();

        // Delta saturation: 26+25 -> 51, 51-26 -> 25
        start_run(4'd2);
        do_mb(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h7F, 1'b0);
        check_mb(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 6'd51, 4'd0, 1'b0);
        chk("sat_qp50_a", 32'(qp50), 32'd23);
        do_mb(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 1'b0);
        check_mb(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 6'd25, 4'd1, 1'b1);
        chk("sat_qp50_b", 32'(qp50), 32'd49);
        step();

        // Three macroblocks back to back; a start pulse mid-run must be ignored
        start_run(4'd3);
        do_mb(8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        check_mb(8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 6'd26, 4'd0, 1'b0);
        do_mb(8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        check_mb(8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 6'd26, 4'd1, 1'b0);
        do_mb(8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        check_mb(8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 6'd26, 4'd2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("run3_idle_busy%0d", k), 32'(busy), 32'd0);
            chk($sformatf("run3_idle_valid%0d", k), 32'(mb_valid), 32'd0);
            chk($sformatf("run3_idle_done%0d", k), 32'(done), 32'd0);
        end

        // Empty run: done next cycle, no busy, no mb_valid
        start_run(4'd0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_valid", 32'(mb_valid), 32'd0);
        step();
        chk("empty_done_clear", 32'(done), 32'd0);
        chk("empty_valid_after", 32'(mb_valid), 32'd0);

        // Reset at idx3 of the second macroblock
        start_run(4'd3);
        do_mb(8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 1'b0);
        check_mb(8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 6'd27, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            egd_value = 8'(8'd10 + 8'(k));
            step();
        end
        chk("pre_reset_sel_idx3", 32'(sel), 32'b01);
        reset_n = 1'b0;
        #1 check_reset_vals("midrun_reset");
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("post_reset_valid%0d", k), 32'(mb_valid), 32'd0);
            chk($sformatf("post_reset_done%0d", k), 32'(done), 32'd0);
            chk($sformatf("post_reset_busy%0d", k), 32'(busy), 32'd0);
        end
        chk("post_reset_type", 32'(mb_type), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/egd_mb_sequencer.md
EGD_MB_SEQUENCER -- requirements
Module: egd_mb_sequencer

Interface
REQ-001 SHALL provide parameter QP_INIT, default 26, the QP value loaded at reset and on each accepted start.
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port start  input  1  one-cycle request to parse a run of macroblocks.
REQ-005 SHALL provide port mb_count  input  4  number of macroblocks in the run, sampled when start is accepted.
REQ-006 SHALL provide port egd_value  input  8  decoded exp-Golomb value from the upstream decoder, valid for the current exp_golomb_sel.
REQ-007 SHALL provide port exp_golomb_sel  output  2  element type request: 2'b00 ue, 2'b01 se, 2'b11 te (2'b10 never driven).
REQ-008 SHALL provide port busy  output  1  high while in PARSE.
REQ-009 SHALL provide port mb_valid  output  1  one-cycle strobe; all field outputs are a new macroblock.
REQ-010 SHALL provide ports mb_type, ref_idx, mvd_x, mvd_y, cbp  output  8 each  registered fields of the last completed macroblock; mvd_x and mvd_y are two's complement.
REQ-011 SHALL provide port qp  output  6  running QP, range 0..51.
REQ-012 SHALL provide port mb_index  output  4  index within the run of the macroblock presented with mb_valid.
REQ-013 SHALL provide port done  output  1  one-cycle strobe marking the end of a run.

Function
REQ-014 SHALL implement states IDLE, PARSE and DONE.
REQ-015 In IDLE, SHALL drive exp_golomb_sel=2'b00 and busy=0, and SHALL capture nothing.
REQ-016 In IDLE with start=1 and mb_count!=0, SHALL go to PARSE, clear element index and mb counter, latch mb_count, and load qp=QP_INIT.
REQ-017 In IDLE with start=1 and mb_count==0, SHALL go to DONE without parsing and with no mb_valid.
REQ-018 SHALL ignore start while in PARSE or DONE.
REQ-019 In PARSE, the element order SHALL be fixed: idx0 mb_type ue, idx1 ref_idx te, idx2 mvd_x se, idx3 mvd_y se, idx4 cbp ue, idx5 qp_delta se.
REQ-020 exp_golomb_sel SHALL be a combinational decode of the element index, so the upstream decoder resolves the element within the same cycle.
REQ-021 SHALL capture egd_value into the shadow register for the current index on every PARSE rising edge, then advance the index (exactly one element per cycle, no stalls).
REQ-022 On the idx5 capture edge, SHALL copy the shadows to the field outputs, update qp, set mb_index to the mb counter, and set mb_valid=1 for the following cycle only.
REQ-023 Field outputs, qp and mb_index SHALL hold their values between mb_valid strobes.
REQ-024 qp update: qp_delta (8-bit signed) SHALL first saturate to -26..+25; sum = qp + delta; if sum<0 add 52; if sum>51 subtract 52; the result is always 0..51.
REQ-025 After the idx5 capture, SHALL wrap idx to 0 and increment the mb counter when more macroblocks remain (back-to-back, 6 cycles per MB), otherwise go to DONE.
REQ-026 done SHALL be 1 exactly in the DONE-state cycle; for a non-empty run this coincides with the final mb_valid; the next state is IDLE.
REQ-027 latency: start accepted at edge E gives first mb_valid in the cycle after edge E+6, and the n-th mb_valid in the cycle after edge E+6n.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, idx 0, mb counter 0, all fields 0, qp=QP_INIT, mb_index 0, mb_valid 0, done 0, busy 0, exp_golomb_sel 2'b00.
REQ-029 Reset during PARSE SHALL discard partial shadows and produce no mb_valid or done after release.

Verification
REQ-030 Single MB: start with mb_count=1, egd_value sequence 3,0,0xFE,5,15,0xFD -> exp_golomb_sel 00,11,01,01,00,01 on consecutive cycles; one mb_valid with mb_type=3, ref_idx=0, mvd_x=0xFE, mvd_y=5, cbp=15, qp=23, mb_index=0; done in the same cycle.
REQ-031 QP wrap: QP_INIT=50, qp_delta +5 -> qp=3; next MB qp_delta -10 -> qp=45.
REQ-032 Saturation: qp=26, qp_delta=0x7F -> delta is saturated to +25, giving 51; qp_delta=0x80 -> delta is saturated to -26, giving 25.
REQ-033 Run of 3 MBs: mb_valid every 6 cycles with mb_index 0,1,2; busy high for 18 cycles; done only with the third mb_valid.
REQ-034 mb_count=0 -> done one cycle after start, busy never high, mb_valid never high; a start pulse during PARSE -> no effect.
REQ-035 reset_n pulsed low at idx3 of the second MB -> all outputs at reset values immediately; no strobes until a new start.
